// File: rtl/caravel_hk_spi.sv
// caravel_hk_spi: housekeeping SPI slave exposing ID and SoC reset
// registers, plus a direct pass-thru from the host SPI to the flash.
module caravel_hk_spi #(
    parameter logic [15:0] MFGR_ID = 16'h0456,
    parameter logic [7:0]  PROD_ID = 8'h11
) (
    input  logic clk_osc,
    input  logic FPGA_rst,
    input  logic spi_sck,
    input  logic spi_csb,
    input  logic spi_sdi,
    output logic spi_sdo,
    output logic spi_sdo_oe,
    input  logic mgmt_flash_csb,
    input  logic mgmt_flash_clk,
    input  logic mgmt_flash_io0,
    output logic mgmt_flash_io1,
    output logic flash_csb,
    output logic flash_clk,
    output logic flash_io0,
    input  logic flash_io1,
    output logic soc_reset
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_PASS,
        S_IGN
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [1:0] csb_sync_q, csb_sync_d;
    logic [1:0] sdi_sync_q, sdi_sync_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_in_q, shift_in_d;
    logic [7:0] shift_out_q, shift_out_d;
    logic [7:0] addr_q, addr_d;
    logic       rd_mode_q, rd_mode_d;
    logic       wr_mode_q, wr_mode_d;
    logic       soc_reset_q, soc_reset_d;

    logic       sck_s, csb_s, sdi_s;
    logic       sck_rise, sck_fall, last_bit;
    logic [7:0] rx_byte;

    // Register map; bit 0 of 0x0B is the only writable state.
    function automatic logic [7:0] reg_read(input logic [7:0] a,
                                            input logic       rst_bit);
        logic [7:0] v;
        case (a)
            8'h01:   v = MFGR_ID[15:8];
            8'h02:   v = MFGR_ID[7:0];
            8'h03:   v = PROD_ID;
            8'h0B:   v = {7'd0, rst_bit};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign sck_s    = sck_sync_q[1];
    assign csb_s    = csb_sync_q[1];
    assign sdi_s    = sdi_sync_q[1];
    assign sck_rise = sck_s & ~sck_sync_q[2];
    assign sck_fall = ~sck_s & sck_sync_q[2];
    assign last_bit = (bit_cnt_q == 3'd7);
    assign rx_byte  = {shift_in_q, sdi_s};
    assign soc_reset = soc_reset_q;

    // Two-flop synchronisers; the third SCK flop keeps the previous value.
    always_comb begin
        sck_sync_d = {sck_sync_q[1:0], spi_sck};
        csb_sync_d = {csb_sync_q[0], spi_csb};
        sdi_sync_d = {sdi_sync_q[0], spi_sdi};
    end

    // State register and all datapath flops.
    always_ff @(posedge clk_osc or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            state_q     <= S_IDLE;
            sck_sync_q  <= 3'b000;
            csb_sync_q  <= 2'b11;
            sdi_sync_q  <= 2'b00;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 7'd0;
            shift_out_q <= 8'd0;
            addr_q      <= 8'd0;
            rd_mode_q   <= 1'b0;
            wr_mode_q   <= 1'b0;
            soc_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            csb_sync_q  <= csb_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            rd_mode_q   <= rd_mode_d;
            wr_mode_q   <= wr_mode_d;
            soc_reset_q <= soc_reset_d;
        end
    end

    // Next state: CSB high aborts everything back to IDLE.
    always_comb begin
        state_d = state_q;
        if (csb_s) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_CMD;
                S_CMD: begin
                    if (sck_rise && last_bit) begin
                        case (rx_byte)
                            8'h40, 8'h80, 8'hC0: state_d = S_ADDR;
                            8'hC4:               state_d = S_PASS;
                            default:             state_d = S_IGN;
                        endcase
                    end
                end
                S_ADDR: if (sck_rise && last_bit) state_d = S_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Shifting, frame handling and register writes.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        rd_mode_d   = rd_mode_q;
        wr_mode_d   = wr_mode_q;
        soc_reset_d = soc_reset_q;
        if (csb_s || state_q == S_IDLE) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
            shift_in_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (last_bit) begin
                case (state_q)
                    S_CMD: begin
                        rd_mode_d = rx_byte[6];
                        wr_mode_d = rx_byte[7];
                    end
                    S_ADDR: begin
                        addr_d      = rx_byte;
                        shift_out_d = reg_read(rx_byte, soc_reset_q);
                    end
                    S_DATA: begin
                        if (wr_mode_q && addr_q == 8'h0B)
                            soc_reset_d = rx_byte[0];
                        addr_d      = addr_q + 8'd1;
                        shift_out_d = reg_read(addr_q + 8'd1, soc_reset_q);
                    end
                    default: ;
                endcase
            end
        end else if (sck_fall && state_q == S_DATA && bit_cnt_q != 3'd0) begin
            // The fall that closes a frame keeps the freshly loaded MSB.
            shift_out_d = {shift_out_q[6:0], 1'b0};
        end
    end

    // Outputs: flash mirrors the SoC except in pass-thru.
    always_comb begin
        spi_sdo        = 1'b0;
        spi_sdo_oe     = 1'b0;
        flash_csb      = mgmt_flash_csb;
        flash_clk      = mgmt_flash_clk;
        flash_io0      = mgmt_flash_io0;
        mgmt_flash_io1 = flash_io1;
        unique case (state_q)
            S_DATA: begin
                if (rd_mode_q) begin
                    spi_sdo    = shift_out_q[7];
                    spi_sdo_oe = 1'b1;
                end
            end
            S_PASS: begin
                flash_csb      = 1'b0;
                flash_clk      = spi_sck;
                flash_io0      = spi_sdi;
                spi_sdo        = flash_io1;
                spi_sdo_oe     = 1'b1;
                mgmt_flash_io1 = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_caravel_hk_spi.sv
// tb_caravel_hk_spi: directed, table-driven and randomized checks of
// the housekeeping SPI slave against a byte-level register model.
module tb_caravel_hk_spi;

    logic clk_osc = 1'b0;
    logic FPGA_rst = 1'b0;
    logic spi_sck = 1'b0;
    logic spi_csb = 1'b1;
    logic spi_sdi = 1'b0;
    logic spi_sdo, spi_sdo_oe;
    logic mgmt_flash_csb = 1'b1;
    logic mgmt_flash_clk = 1'b0;
    logic mgmt_flash_io0 = 1'b0;
    logic mgmt_flash_io1;
    logic flash_csb, flash_clk, flash_io0, flash_io1;
    logic soc_reset;

    logic fio_ovr_en = 1'b0;
    logic fio_ovr = 1'b0;
    logic flash_do = 1'b0;
    assign flash_io1 = fio_ovr_en ? fio_ovr : flash_do;

    caravel_hk_spi dut (
        .clk_osc(clk_osc),
        .FPGA_rst(FPGA_rst),
        .spi_sck(spi_sck),
        .spi_csb(spi_csb),
        .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo),
        .spi_sdo_oe(spi_sdo_oe),
        .mgmt_flash_csb(mgmt_flash_csb),
        .mgmt_flash_clk(mgmt_flash_clk),
        .mgmt_flash_io0(mgmt_flash_io0),
        .mgmt_flash_io1(mgmt_flash_io1),
        .flash_csb(flash_csb),
        .flash_clk(flash_clk),
        .flash_io0(flash_io0),
        .flash_io1(flash_io1),
        .soc_reset(soc_reset)
    );

    always #5 clk_osc = ~clk_osc;

    // Minimal mode-0 SPI flash: 32 header bits, then data from fmem.
    logic [7:0]  fmem [4];
    logic [31:0] fhdr = 32'd0;
    int          fcnt = 0;
    logic        armed = 1'b0;
    int          fbi;
    int          fidx;
    logic [7:0]  fbyte;
    always @(flash_clk or flash_csb) begin
        if (flash_csb) begin
            fcnt  = 0;
            armed = 1'b0;
        end else if (flash_clk && armed) begin
            if (fcnt < 32) fhdr = {fhdr[30:0], flash_io0};
            fcnt++;
        end else if (!flash_clk) begin
            armed = 1'b1;
            if (fcnt >= 32) begin
                fbi      = fcnt - 32;
                fidx     = (int'(fhdr[1:0]) + fbi / 8) % 4;
                fbyte    = fmem[fidx];
                flash_do = fbyte[7 - (fbi % 8)];
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic oe_or, oe_and, fcsb_or;
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic [7:0] rx;

    task automatic mon_clr();
        oe_or = 1'b0;
        oe_and = 1'b1;
        fcsb_or = 1'b0;
    endtask

    task automatic sbits(input logic [7:0] tx, input int n,
                         output logic [7:0] r);
        r = 8'd0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_sdi = tx[i];
            #50;
            r[i] = spi_sdo;
            oe_or = oe_or | spi_sdo_oe;
            oe_and = oe_and & spi_sdo_oe;
            fcsb_or = fcsb_or | flash_csb;
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    task automatic sbyte(input logic [7:0] tx, output logic [7:0] r);
        sbits(tx, 8, r);
    endtask

    task automatic sstart();
        spi_csb = 1'b0;
        #60;
    endtask

    task automatic sstop();
        #50;
        spi_csb = 1'b1;
        #100;
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] addr,
                        input int n);
        logic [7:0] d;
        sstart();
        sbyte(cmd, d);
        sbyte(addr, d);
        mon_clr();
        for (int i = 0; i < n; i++) sbyte(tx_buf[i], rx_buf[i]);
        sstop();
    endtask

    // Register contents as the host should see them.
    function automatic logic [7:0] ref_read(input logic [7:0] a,
                                            input logic srst);
        if (a == 8'h01) return 8'h04;
        if (a == 8'h02) return 8'h56;
        if (a == 8'h03) return 8'h11;
        if (a == 8'h0B) return {7'd0, srst};
        return 8'h00;
    endfunction

    typedef struct {
        logic [3:0] in;
        logic [3:0] exp;
    } mir_vec_t;
    mir_vec_t mv [8];

    logic       model_soc;
    logic [7:0] cmd, addr, a, e;
    logic       rd, wr, valid;
    int         kind, nb;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // in = {mgmt_csb, mgmt_clk, mgmt_io0, flash_io1}
        // exp = {flash_csb, flash_clk, flash_io0, mgmt_io1}
        mv[0] = '{4'b0000, 4'b0000};
        mv[1] = '{4'b0001, 4'b0001};
        mv[2] = '{4'b0010, 4'b0010};
        mv[3] = '{4'b0100, 4'b0100};
        mv[4] = '{4'b1000, 4'b1000};
        mv[5] = '{4'b0101, 4'b0101};
        mv[6] = '{4'b1010, 4'b1010};
        mv[7] = '{4'b1111, 4'b1111};
        fmem[0] = 8'h6F;
        fmem[1] = 8'hA5;
        fmem[2] = 8'h3C;
        fmem[3] = 8'h81;
        mon_clr();

        #23;
        chk("rst_sdo", spi_sdo, 1'b0);
        chk("rst_oe", spi_sdo_oe, 1'b0);
        chk("rst_soc", soc_reset, 1'b0);
        chk("rst_fcsb", flash_csb, 1'b1);
        FPGA_rst = 1'b1;
        #50;
        model_soc = 1'b0;

        // ID reads, including address auto-increment.
        xfer(8'h40, 8'h01, 2);
        chk("id_hi", rx_buf[0], 8'h04);
        chk("id_lo", rx_buf[1], 8'h56);
        chk("id_oe", oe_and, 1'b1);
        xfer(8'h40, 8'h03, 1);
        chk("prod_id", rx_buf[0], 8'h11);
        xfer(8'h40, 8'h20, 1);
        chk("unmapped", rx_buf[0], 8'h00);

        // soc_reset write, read back, clear.
        tx_buf[0] = 8'h01;
        xfer(8'h80, 8'h0B, 1);
        chk("soc_set", soc_reset, 1'b1);
        chk("wr_oe", oe_or, 1'b0);
        xfer(8'h40, 8'h0B, 1);
        chk("soc_rdbk", rx_buf[0], 8'h01);
        tx_buf[0] = 8'h00;
        xfer(8'h80, 8'h0B, 1);
        chk("soc_clr", soc_reset, 1'b0);

        // Address wrap 0xFF -> 0x00 -> 0x01.
        xfer(8'h40, 8'hFF, 3);
        chk("wrap_ff", rx_buf[0], 8'h00);
        chk("wrap_00", rx_buf[1], 8'h00);
        chk("wrap_01", rx_buf[2], 8'h04);

        // Pass-thru read of flash address 0.
        sstart();
        sbyte(8'hC4, rx);
        mon_clr();
        sbyte(8'h03, rx);
        sbyte(8'h00, rx);
        sbyte(8'h00, rx);
        sbyte(8'h00, rx);
        sbyte(8'hFF, rx);
        chk("pt_data", rx, 8'h6F);
        chk("pt_hdr", fhdr, 32'h0300_0000);
        chk("pt_fcsb_low", fcsb_or, 1'b0);
        chk("pt_oe", oe_and, 1'b1);
        chk("pt_mgmt_io1", mgmt_flash_io1, 1'b0);
        sstop();
        chk("pt_exit", flash_csb, 1'b1);

        // Set soc_reset, then ignored command and aborted write.
        tx_buf[0] = 8'h01;
        xfer(8'h80, 8'h0B, 1);
        tx_buf[0] = 8'h00;
        tx_buf[1] = 8'h00;
        xfer(8'h12, 8'h0B, 2);
        chk("ign_oe", oe_or, 1'b0);
        chk("ign_soc", soc_reset, 1'b1);
        sstart();
        sbyte(8'h80, rx);
        sbyte(8'h0B, rx);
        sbits(8'h00, 5, rx);
        sstop();
        chk("abort_soc", soc_reset, 1'b1);

        // Reset mid-read, then a clean transaction.
        sstart();
        sbyte(8'h40, rx);
        sbyte(8'h01, rx);
        sbits(8'h00, 4, rx);
        FPGA_rst = 1'b0;
        #1;
        chk("mrst_sdo", spi_sdo, 1'b0);
        chk("mrst_oe", spi_sdo_oe, 1'b0);
        chk("mrst_soc", soc_reset, 1'b0);
        chk("mrst_fcsb", flash_csb, 1'b1);
        spi_csb = 1'b1;
        spi_sck = 1'b0;
        #100;
        FPGA_rst = 1'b1;
        #50;
        model_soc = 1'b0;
        xfer(8'h40, 8'h01, 1);
        chk("post_rst", rx_buf[0], 8'h04);

        // Idle mirroring of the management flash pins.
        fio_ovr_en = 1'b1;
        foreach (mv[i]) begin
            mgmt_flash_csb = mv[i].in[3];
            mgmt_flash_clk = mv[i].in[2];
            mgmt_flash_io0 = mv[i].in[1];
            fio_ovr = mv[i].in[0];
            #3;
            chk("mirror", {flash_csb, flash_clk, flash_io0, mgmt_flash_io1},
                mv[i].exp);
        end
        mgmt_flash_csb = 1'b1;
        mgmt_flash_clk = 1'b0;
        mgmt_flash_io0 = 1'b0;
        fio_ovr_en = 1'b0;
        #20;

        // Random transactions against the register model.
        for (int t = 0; t < 25; t++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) cmd = 8'h40;
            else if (kind == 1) cmd = 8'h80;
            else if (kind == 2) cmd = 8'hC0;
            else begin
                cmd = 8'($urandom);
                while (cmd == 8'h40 || cmd == 8'h80 || cmd == 8'hC0 ||
                       cmd == 8'hC4)
                    cmd = 8'($urandom);
            end
            valid = (kind != 3);
            rd = valid && (cmd != 8'h80);
            wr = valid && (cmd != 8'h40);
            case ($urandom_range(0, 3))
                0: addr = 8'h0B;
                1: addr = 8'($urandom_range(0, 15));
                2: addr = 8'hFE + 8'($urandom_range(0, 1));
                default: addr = 8'($urandom);
            endcase
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) tx_buf[i] = 8'($urandom);
            xfer(cmd, addr, nb);
            a = addr;
            for (int i = 0; i < nb; i++) begin
                e = rd ? ref_read(a, model_soc) : 8'h00;
                chk("rand_rd", rx_buf[i], e);
                if (wr && a == 8'h0B) model_soc = tx_buf[i][0];
                a = a + 8'd1;
            end
            chk("rand_oe", rd ? oe_and : oe_or, rd);
            chk("rand_soc", soc_reset, model_soc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
